pos_ramp: RTL and testbench

Upstream stage of the servo PWM top. Accepts target-position commands through a valid/ready handshake. Drives the PWM block's 4-bit `posT` input one unit at a time, at a programmable number of 20 ms frames per step, so the servo slews smoothly instead of jumping. `posT` changes only on frame boundaries, so the PWM stage never sees a mid-frame position change.

---
 rtl/servo_pkg.sv | 19 +
 rtl/frame_timer.sv | 34 +++
 rtl/pos_ramp.sv | 107 ++++++++++
 tb/tb_pos_ramp.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Constants and types shared by the servo position ramp and the PWM stage,
// so both blocks agree on frame length and position width.
package servo_pkg;

   localparam int W_POS        = 4;
   localparam int MAX_POS      = 10;
   localparam int FRAME_CYCLES = 1_000_000;

   typedef enum logic {
      IDLE,
      MOVE
   } state_t;

   // Counter width for a modulo-n count; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running servo frame counter with a registered one-clock tick on the
// last clock of every frame.
module frame_timer #(
   parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES
) (
   input  logic clk,
   input  logic i_reset_n,
   output logic o_frame_tick
);
   import servo_pkg::*;

   localparam int             CW   = cnt_width(FRAME_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(FRAME_CYCLES - 1);

   logic [CW-1:0] r_fcnt;
   logic          r_tick;
   logic [CW-1:0] w_fcnt_next;

   assign w_fcnt_next = (r_fcnt == LAST) ? '0 : r_fcnt + 1'b1;

   // The tick is registered from the next count so it lines up with fcnt == LAST.
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         r_fcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_fcnt <= w_fcnt_next;
         r_tick <= (w_fcnt_next == LAST);
      end
   end

   assign o_frame_tick = r_tick;

endmodule

// File: rtl/pos_ramp.sv
// Servo position ramp: accepts target commands and slews posT one unit per
// STEP_FRAMES frames, changing it only on the first clock of a frame.
module pos_ramp #(
   parameter int W_POS        = servo_pkg::W_POS,
   parameter int MAX_POS      = servo_pkg::MAX_POS,
   parameter int INIT_POS     = 1,
   parameter int FRAME_CYCLES = servo_pkg::FRAME_CYCLES,
   parameter int STEP_FRAMES  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W_POS-1:0] cmd_pos,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   output logic [W_POS-1:0] posT,
   output logic             busy,
   output logic             frame_tick
);
   import servo_pkg::*;

   localparam int               SW    = cnt_width(STEP_FRAMES);
   localparam logic [SW-1:0]    SLAST = SW'(STEP_FRAMES - 1);
   localparam logic [W_POS-1:0] MAXP  = W_POS'(MAX_POS);
   localparam logic [W_POS-1:0] INITP = W_POS'(INIT_POS);

   state_t           r_state, r_state_next;
   logic [W_POS-1:0] r_pos, r_pos_next;
   logic [W_POS-1:0] r_target, r_target_next;
   logic [SW-1:0]    r_scnt, r_scnt_next;
   logic             r_ready, r_ready_next;
   logic             r_busy, r_busy_next;

   logic             w_tick;
   logic             w_accept;
   logic [W_POS-1:0] w_clamped;
   logic [W_POS-1:0] w_pos_step;

   frame_timer #(
      .FRAME_CYCLES(FRAME_CYCLES)
   ) u_frame_timer (
      .clk         (clk),
      .i_reset_n   (reset),
      .o_frame_tick(w_tick)
   );

   assign w_accept   = cmd_valid && r_ready;
   assign w_clamped  = (cmd_pos > MAXP) ? MAXP : cmd_pos;
   // Unsigned compare sets the direction, so posT stays between start and target.
   assign w_pos_step = (r_target > r_pos) ? r_pos + 1'b1 : r_pos - 1'b1;

   always_comb begin
      r_state_next  = r_state;
      r_pos_next    = r_pos;
      r_target_next = r_target;
      r_scnt_next   = r_scnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               r_target_next = w_clamped;
               r_scnt_next   = '0;
               if (w_clamped != r_pos) begin
                  r_state_next = MOVE;
               end
            end
         end
         MOVE: begin
            if (w_tick) begin
               if (r_scnt == SLAST) begin
                  r_scnt_next = '0;
                  r_pos_next  = w_pos_step;
                  if (w_pos_step == r_target) begin
                     r_state_next = IDLE;
                  end
               end else begin
                  r_scnt_next = r_scnt + 1'b1;
               end
            end
         end
      endcase
      r_ready_next = (r_state_next == IDLE);
      r_busy_next  = (r_state_next == MOVE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_pos    <= INITP;
         r_target <= INITP;
         r_scnt   <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= r_state_next;
         r_pos    <= r_pos_next;
         r_target <= r_target_next;
         r_scnt   <= r_scnt_next;
         r_ready  <= r_ready_next;
         r_busy   <= r_busy_next;
      end
   end

   assign cmd_ready  = r_ready;
   assign posT       = r_pos;
   assign busy       = r_busy;
   assign frame_tick = w_tick;

endmodule

// File: tb/tb_pos_ramp.sv
// Directed bench for pos_ramp with an 8-clock frame and 2 frames per step.
module tb_pos_ramp;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] cmd_pos = 4'd0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] posT;
   logic       busy;
   logic       frame_tick;

   int n_cmp = 0;
   int n_bad = 0;

   pos_ramp #(
      .W_POS       (4),
      .MAX_POS     (10),
      .INIT_POS    (1),
      .FRAME_CYCLES(8),
      .STEP_FRAMES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_pos   (cmd_pos),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .posT      (posT),
      .busy      (busy),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advances to the next negedge on which frame_tick is high; n = clocks waited.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 64);
      if (frame_tick !== 1'b1) chk("tick_wait", frame_tick, 1);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b0;
      cmd_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      chk("rst_pos", posT, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_tick", frame_tick, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_ready", cmd_ready, 1);
      chk("rel_busy", busy, 0);
   endtask

   task automatic send(input int pos);
      cmd_pos = pos[3:0];
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("cmd %0d -> posT=%0d busy=%0d ready=%0d", pos, posT, busy, cmd_ready);
   endtask

   // Each step lands on the clock after the second tick following the previous one.
   task automatic move_check(input int from, input int to, input bit fin);
      int p, q, n;
      p = from;
      while (p != to) begin
         q = (to > p) ? p + 1 : p - 1;
         wait_tick(n);
         wait_tick(n);
         chk("hold_pos", posT, p);
         chk("busy_mv", busy, 1);
         @(negedge clk);
         chk("step_pos", posT, q);
         $display("step %0d -> %0d (posT=%0d)", p, q, posT);
         p = q;
      end
      if (fin) begin
         chk("done_busy", busy, 0);
         chk("done_ready", cmd_ready, 1);
      end
   endtask

   initial begin
      int n;

      do_reset(3);
      wait_tick(n);
      chk("first_tick", n, 6);
      wait_tick(n);
      chk("tick_period", n, 8);

      // Up move 1 -> 4
      @(negedge clk);
      send(4);
      chk("acc_busy", busy, 1);
      chk("acc_ready", cmd_ready, 0);
      chk("acc_pos", posT, 1);
      move_check(1, 4, 1'b1);

      // Same position is consumed without a move
      send(4);
      chk("same_busy", busy, 0);
      chk("same_ready", cmd_ready, 1);
      chk("same_pos", posT, 4);

      // Clamp 15 -> 10, with a blocked command 9 during the move
      send(15);
      chk("clamp_busy", busy, 1);
      send(9);
      chk("blk_ready", cmd_ready, 0);
      move_check(4, 10, 1'b1);

      // Down move 10 -> 2
      send(2);
      chk("down_busy", busy, 1);
      move_check(10, 2, 1'b1);

      // Reset in the middle of a 1 -> 8 move
      do_reset(1);
      send(8);
      chk("mid_busy", busy, 1);
      move_check(1, 5, 1'b0);
      do_reset(1);
      wait_tick(n);
      chk("fcnt_restart", n, 6);
      wait_tick(n);
      chk("tick_period2", n, 8);

      // Accept on a frame_tick clock; valid stays high across the move
      cmd_pos = 4'd3;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("sim_busy", busy, 1);
      cmd_pos = 4'd5;
      n = 0;
      while (posT == 4'd1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("sim_first_step", n, 16);
      chk("sim_pos", posT, 2);
      $display("simultaneous accept: first step %0d clocks after accept edge", n);
      move_check(2, 3, 1'b1);
      @(negedge clk);
      chk("reacc_busy", busy, 1);
      chk("reacc_ready", cmd_ready, 0);
      cmd_valid = 1'b0;
      move_check(3, 5, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
